// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix-keypad scanner: drives active-low rows, debounces whole-frame snapshots
// and queues one key code per new press in a first-word fall-through FIFO.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 8,
  parameter int unsigned DEBOUNCE_SCANS = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_100mhz,
  input  logic          reset_n,
  input  logic          enable,
  output logic [3:0]    row_out,
  input  logic [3:0]    col_in,
  output logic          key_valid,
  output logic [3:0]    key_code,
  input  logic          key_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          irq
);

  localparam int unsigned SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [STW-1:0] STABLE_MAX = STW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0]  FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVAL, S_EMIT} state_e;

  state_e          state_q;
  logic [1:0]      row_q;
  logic [SW-1:0]   slot_q;
  logic [3:0]      row_out_q;
  logic [15:0]     raw_q, prev_q, deb_q, pend_q;
  logic [STW-1:0]  stable_q;
  logic [3:0]      col_s1_q, col_s2_q;

  logic [3:0]      pressed_c;
  logic [1:0]      row_inc_c;
  logic [STW-1:0]  stable_nxt_c;
  logic [15:0]     new_map_c, pend_clr_c;
  logic [3:0]      emit_idx_c;

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, overflow_q;
  logic            push_c, pop_c, full_c, push_acc_c;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
    end
  end

  assign pressed_c  = ~col_s2_q;
  assign row_inc_c  = row_q + 2'd1;
  assign new_map_c  = raw_q & ~deb_q;

  always_comb begin
    stable_nxt_c = '0;
    if (raw_q == prev_q) begin
      stable_nxt_c = (stable_q == STABLE_MAX) ? stable_q : stable_q + STW'(1);
    end
  end

  // Lowest pending key index is emitted first
  always_comb begin
    emit_idx_c = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) emit_idx_c = 4'(i);
    end
    pend_clr_c = pend_q & ~(16'd1 << emit_idx_c);
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      slot_q    <= '0;
      row_out_q <= 4'hF;
      raw_q     <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      stable_q  <= '0;
    end else if (!enable) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      slot_q    <= '0;
      row_out_q <= 4'hF;
      raw_q     <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      stable_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_SCAN;
          row_q     <= '0;
          slot_q    <= '0;
          row_out_q <= 4'b1110;
        end
        S_SCAN: begin
          if (slot_q == SLOT_LAST) begin
            raw_q[{row_q, 2'b00} +: 4] <= pressed_c;
            slot_q <= '0;
            if (row_q == 2'd3) begin
              state_q   <= S_EVAL;
              row_out_q <= 4'hF;
            end else begin
              row_q     <= row_inc_c;
              row_out_q <= ~(4'b0001 << row_inc_c);
            end
          end else begin
            slot_q <= slot_q + SW'(1);
          end
        end
        S_EVAL: begin
          stable_q <= stable_nxt_c;
          prev_q   <= raw_q;
          row_q    <= '0;
          slot_q   <= '0;
          if (stable_nxt_c == STABLE_MAX) deb_q <= raw_q;
          if (stable_nxt_c == STABLE_MAX && new_map_c != '0) begin
            state_q <= S_EMIT;
            pend_q  <= new_map_c;
          end else begin
            state_q   <= S_SCAN;
            row_out_q <= 4'b1110;
          end
        end
        S_EMIT: begin
          pend_q <= pend_clr_c;
          if (pend_clr_c == '0) begin
            state_q   <= S_SCAN;
            row_out_q <= 4'b1110;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head pops in the same cycle
  assign push_c     = (state_q == S_EMIT) && enable;
  assign pop_c      = valid_q && key_ready;
  assign full_c     = (count_q == FIFO_FULL);
  assign push_acc_c = push_c && (!full_c || pop_c);

  always_comb begin
    count_d = count_q;
    case ({push_acc_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc_c) begin
        mem_q[wr_ptr_q] <= emit_idx_c;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
      else if (ovf_clr)               overflow_q <= 1'b0;
    end
  end

  assign row_out    = row_out_q;
  assign key_valid  = valid_q;
  assign irq        = valid_q;
  assign key_code   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
